pipe_reg_chain: RTL and testbench
=================================

// Module: pipe_reg_chain
// PURPOSE
//   Parametrised pipeline register chain: successor to the fixed 32-bit reset flop.
//   DEPTH register stages of WIDTH bits with per-stage valid and a valid/ready handshake.
//   Empty stages fill even while the output is stalled (bubble collapse). Adds synchronous flush.
//   Sits between processor pipeline stages (IF/ID/EX/MEM/WB) wherever stall and flush are needed.
// PARAMETERS
//   WIDTH      32   payload width in bits (>=1)
//   DEPTH      1    number of register stages (>=1); DEPTH=1 is a single handshaked slice
//   RESET_VAL  0    value loaded into every data register on reset (WIDTH bits)
//   CNT_W      $clog2(DEPTH+1)  width of occupancy output (derived, do not override)
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous, active-high reset
//   flush      in   1       synchronous squash of all in-flight entries
//   in_valid   in   1       upstream presents in_data
//   in_ready   out  1       chain accepts in_data this cycle
//   in_data    in   WIDTH   payload from upstream
//   out_valid  out  1       last stage holds a valid entry
//   out_ready  in   1       downstream accepts out_data this cycle
//   out_data   out  WIDTH   payload of the last stage
//   occupancy  out  CNT_W   number of valid stages, 0..DEPTH
// BEHAVIOUR
//   - Stages are indexed 0 (input) .. DEPTH-1 (output); each stage holds v[i] and d[i].
//   - Reset (reset=1 at posedge): all v[i]<=0, all d[i]<=RESET_VAL, so out_valid=0,
//     out_data=RESET_VAL, occupancy=0. Reset has priority over flush and the handshake.
//   - Ready chain (combinational): rdy[DEPTH]=out_ready; rdy[i]=~v[i] | rdy[i+1]; in_ready=rdy[0].
//   - Stage i loads when rdy[i]=1: v[i]<=v[i-1] (stage 0: in_valid), d[i]<=d[i-1] (stage 0: in_data).
//     When rdy[i]=0 the stage holds v[i] and d[i] unchanged.
//   - d[i] loads only when the incoming valid is 1. An invalid bubble does not overwrite data,
//     so out_data is stable whenever out_valid=0.
//   - Transfers: input when in_valid&in_ready; output when out_valid&out_ready.
//   - Latency is DEPTH cycles when out_ready is held high. Throughput is 1 entry/cycle.
//   - No combinational path from in_data to out_data.
//   - Path from out_ready to in_ready is combinational through up to DEPTH stages; this is accepted.
//   - Full: all v=1 and out_ready=0 gives in_ready=0. If all v=1 and out_ready=1,
//     in_ready=1 and the chain accepts and emits in the same cycle (no full-cycle bubble).
//   - Empty: occupancy=0, out_valid=0, in_ready=1 regardless of out_ready.
//   - Stall: in_valid=1 with in_ready=0 accepts nothing. Upstream holds in_data; not checked here.
//   - Flush=1 at posedge: all v[i]<=0. The same-cycle input is dropped and the same-cycle output
//     is still emitted if out_valid&out_ready. d[i] is not cleared.
//     Next cycle occupancy=0 and in_ready=1.
//   - Reset mid-stream: in-flight entries are discarded; no output transfer is attributed to that cycle.
//   - occupancy is registered. Next value = popcount of next v[], computed as
//     current + in_xfer - out_xfer, or 0 on reset/flush. It never exceeds DEPTH (no wrap).
// STRUCTURE
//   - Shared header pipe_defs.vh: default WIDTH (32) and RESET_VAL (32'd0), shared with other
//     pipeline blocks so every stage register agrees on them.
//   - Sub-module pipe_reg_slice (WIDTH, RESET_VAL): one valid/data stage with load enable,
//     sync reset and flush. pipe_reg_chain instantiates DEPTH of these in a generate loop and owns
//     the ready chain and the occupancy counter.
// TESTING
//   1. Reset: hold reset 2 cycles with in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0,
//      out_data=0, occupancy=0 throughout and after.
//   2. Streaming, DEPTH=3, out_ready=1: push 1,2,3,4,5 on consecutive cycles ->
//      out_data 1..5 on cycles 3..7, all with out_valid=1, in_ready=1 throughout.
//   3. Backpressure, DEPTH=3: out_ready=0, push 10,11,12,13 -> first three accepted, in_ready=0
//      at the 4th, occupancy=3. Raise out_ready -> 10,11,12,13 emitted in order, no loss or duplication.
//   4. Full pass-through: chain full with 10,11,12, out_ready=1, in_valid=1, data 20 ->
//      10 emitted and 20 accepted in the same cycle, occupancy stays 3.
//   5. Flush: occupancy=2, flush=1 with in_valid=1, data 7 -> next cycle occupancy=0,
//      out_valid=0, and 7 never appears at the output.
//   6. Bubble collapse, DEPTH=4: push A, idle 2 cycles, push B with out_ready=0 throughout ->
//      A and B occupy stages 3 and 2, occupancy=2, in_ready=1.
//   Scoreboard on all tests: output order = input order minus flushed entries.
//   Random in_valid/out_ready soak at WIDTH=8, DEPTH=1 and DEPTH=5.

Source files
------------

// File: rtl/pipe_reg_chain_pkg.sv
// Shared defaults for pipeline stage registers so every stage agrees on width and reset value.
// No logic; imported by the chain top.
// No handshake of its own.
package pipe_reg_chain_pkg;

    localparam int          DEF_WIDTH     = 32;
    localparam logic [31:0] DEF_RESET_VAL = 32'd0;

endpackage

// File: rtl/pipe_reg_slice.sv
// One valid/data pipeline stage with load enable, sync reset and flush.
// Latency: 1 cycle from load to valid/data.
// Backpressure: holds state whenever load is low; the parent decides load.
module pipe_reg_slice #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (load)
                valid <= in_valid;
            // Bubbles and squashed entries never touch data, keeping out_data stable while invalid.
            if (load && in_valid && !flush)
                data <= in_data;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage handshaked register chain with bubble collapse, flush and registered occupancy.
// Latency: DEPTH cycles with out_ready held high; 1 entry/cycle throughput.
// Backpressure: ready ripples combinationally back from out_ready; empty stages keep filling.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL),
    localparam int              CNT_W     = $clog2(DEPTH + 1)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy
);

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic             in_xfer;
    logic             out_xfer;

    // A stage may load if it is empty or the stage ahead of it is loading too.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--)
            rdy[k] = ~v[k] | rdy[k+1];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        if (i == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
        end else begin : g_body
            assign src_valid = v[i-1];
            assign src_data  = d[i-1];
        end

        pipe_reg_slice #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_slice (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .load     (rdy[i]),
            .in_valid (src_valid),
            .in_data  (src_data),
            .valid    (v[i]),
            .data     (d[i])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign in_xfer   = in_valid & rdy[0];
    assign out_xfer  = v[DEPTH-1] & out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush)
            occupancy <= '0;
        else
            occupancy <= occupancy + CNT_W'(in_xfer) - CNT_W'(out_xfer);
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed and random checks of pipe_reg_chain against a positional queue model.
// Four instances cover DEPTH 3/4 at WIDTH 32 and DEPTH 1/5 at WIDTH 8.
module tb_pipe_reg_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        iv [4];
    logic        ordy [4];
    logic        fl [4];
    logic        rs [4];
    logic [31:0] idat [4];

    logic        ov0, ov1, ov2, ov3;
    logic        ir0, ir1, ir2, ir3;
    logic [31:0] od0, od1;
    logic [7:0]  od2, od3;
    logic [1:0]  oc0;
    logic [2:0]  oc1, oc3;
    logic [0:0]  oc2;

    pipe_reg_chain #(.WIDTH(32), .DEPTH(3)) u_d3 (
        .clk(clk), .reset(rs[0]), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir0),
        .in_data(idat[0]), .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0), .occupancy(oc0));
    pipe_reg_chain #(.WIDTH(32), .DEPTH(4)) u_d4 (
        .clk(clk), .reset(rs[1]), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir1),
        .in_data(idat[1]), .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1), .occupancy(oc1));
    pipe_reg_chain #(.WIDTH(8), .DEPTH(1)) u_w8d1 (
        .clk(clk), .reset(rs[2]), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir2),
        .in_data(idat[2][7:0]), .out_valid(ov2), .out_ready(ordy[2]), .out_data(od2), .occupancy(oc2));
    pipe_reg_chain #(.WIDTH(8), .DEPTH(5)) u_w8d5 (
        .clk(clk), .reset(rs[3]), .flush(fl[3]), .in_valid(iv[3]), .in_ready(ir3),
        .in_data(idat[3][7:0]), .out_valid(ov3), .out_ready(ordy[3]), .out_data(od3), .occupancy(oc3));

    int          sel = 0;
    logic        c_ov, c_ir;
    logic [31:0] c_od;
    logic [3:0]  c_oc;

    always_comb begin
        c_ov = ov0; c_ir = ir0; c_od = od0; c_oc = {2'b0, oc0};
        case (sel)
            1: begin c_ov = ov1; c_ir = ir1; c_od = od1;          c_oc = {1'b0, oc1}; end
            2: begin c_ov = ov2; c_ir = ir2; c_od = {24'b0, od2}; c_oc = {3'b0, oc2}; end
            3: begin c_ov = ov3; c_ir = ir3; c_od = {24'b0, od3}; c_oc = {1'b0, oc3}; end
            default: ;
        endcase
    end

    int total = 0;
    int bad   = 0;

    // Model: accepted entries oldest first, each with its stage position.
    logic [31:0] mdat [$];
    int          mpos [$];
    int          mdepth = 3;
    logic [31:0] mmask  = 32'hFFFF_FFFF;
    bit          mknown = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic use_dut(input int s, input int depth, input logic [31:0] mask);
        sel    = s;
        mdepth = depth;
        mmask  = mask;
        mknown = 0;
        mdat.delete();
        mpos.delete();
    endtask

    task automatic step(input bit v_i, input bit r_o, input bit f, input bit r, input logic [31:0] dat);
        int lim;
        int np;
        int npos [$];
        bit e_ov;
        bit e_ir;
        for (int j = 0; j < 4; j++) begin
            iv[j] = 1'b0; ordy[j] = 1'b0; fl[j] = 1'b0; rs[j] = 1'b0; idat[j] = '0;
        end
        iv[sel] = v_i; ordy[sel] = r_o; fl[sel] = f; rs[sel] = r; idat[sel] = dat;
        #1;
        e_ov = (mpos.size() > 0) && (mpos[0] == mdepth - 1);
        // Each entry advances one slot if the slot ahead will be free; the head may leave on out_ready.
        lim = r_o ? mdepth : mdepth - 1;
        for (int k = 0; k < mpos.size(); k++) begin
            np = (mpos[k] + 1 < lim) ? mpos[k] + 1 : lim;
            npos.push_back(np);
            lim = np - 1;
        end
        e_ir = (lim >= 0);
        if (mknown) begin
            chk("out_valid", {31'b0, c_ov}, {31'b0, e_ov});
            chk("in_ready", {31'b0, c_ir}, {31'b0, e_ir});
            chk("occupancy", {28'b0, c_oc}, mpos.size());
            if (e_ov) chk("out_data", c_od, mdat[0]);
        end
        if (r) begin
            mdat.delete();
            mpos.delete();
            mknown = 1;
        end else begin
            mpos = npos;
            if (e_ov && r_o) begin
                void'(mdat.pop_front());
                void'(mpos.pop_front());
            end
            if (f) begin
                mdat.delete();
                mpos.delete();
            end else if (v_i && e_ir) begin
                mdat.push_back(dat & mmask);
                mpos.push_back(0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int j = 0; j < 4; j++) begin
            iv[j] = 1'b0; ordy[j] = 1'b0; fl[j] = 1'b0; rs[j] = 1'b0; idat[j] = '0;
        end
        @(posedge clk);
        #1;

        // Reset with upstream pushing
        use_dut(0, 3, 32'hFFFF_FFFF);
        step(1, 1, 0, 1, 32'hDEAD_BEEF);
        chk("rst_data_1", c_od, 32'h0);
        step(1, 1, 0, 1, 32'hDEAD_BEEF);
        chk("rst_valid", {31'b0, c_ov}, 32'h0);
        chk("rst_data_2", c_od, 32'h0);
        chk("rst_occ", {28'b0, c_oc}, 32'h0);

        // Streaming 1..5, appearing DEPTH cycles later
        for (int k = 0; k < 8; k++) begin
            if (k >= 3) begin
                chk("stream_valid", {31'b0, c_ov}, 32'h1);
                chk("stream_data", c_od, k - 2);
            end
            step(k < 5, 1, 0, 0, k + 1);
        end

        // Backpressure: three fit, the fourth waits
        step(1, 0, 0, 0, 10);
        step(1, 0, 0, 0, 11);
        step(1, 0, 0, 0, 12);
        chk("bp_full_rdy", {31'b0, c_ir}, 32'h0);
        chk("bp_full_occ", {28'b0, c_oc}, 32'h3);
        step(1, 0, 0, 0, 13);
        step(1, 1, 0, 0, 13);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0);
        chk("bp_drained", {28'b0, c_oc}, 32'h0);

        // Full pass-through: emit 10 and accept 20 in one cycle
        step(1, 0, 0, 0, 10);
        step(1, 0, 0, 0, 11);
        step(1, 0, 0, 0, 12);
        chk("pass_head", c_od, 32'd10);
        step(1, 1, 0, 0, 20);
        chk("pass_occ", {28'b0, c_oc}, 32'h3);
        chk("pass_next", c_od, 32'd11);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0);

        // Flush with two in flight, dropping a same-cycle push
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 2);
        chk("fl_occ_before", {28'b0, c_oc}, 32'h2);
        step(1, 0, 1, 0, 7);
        chk("fl_occ", {28'b0, c_oc}, 32'h0);
        chk("fl_valid", {31'b0, c_ov}, 32'h0);
        chk("fl_rdy", {31'b0, c_ir}, 32'h1);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0);
        // Flush while the head leaves
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 30 + k);
        step(0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 40);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0);

        // Bubble collapse at DEPTH 4
        use_dut(1, 4, 32'hFFFF_FFFF);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 32'hA);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 32'hB);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("bub_occ", {28'b0, c_oc}, 32'h2);
        chk("bub_rdy", {31'b0, c_ir}, 32'h1);
        chk("bub_head", c_od, 32'hA);
        step(0, 1, 0, 0, 0);
        chk("bub_second", c_od, 32'hB);
        step(0, 1, 0, 0, 0);

        // Random soak at WIDTH 8, DEPTH 1 and 5
        for (int s = 2; s < 4; s++) begin
            use_dut(s, (s == 2) ? 1 : 5, 32'h0000_00FF);
            step(0, 0, 0, 1, 0);
            for (int k = 0; k < 600; k++)
                step($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                     $urandom_range(0, 149) == 0, $urandom);
            for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 0);
            chk("soak_empty", {28'b0, c_oc}, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
